// File: rtl/median_last_actor.sv
// Median selector: pops a control tuple plus up to BUFF_SIZE pixels and emits the rank-median_pos value.
// Optional pivot shortcut pass enabled by defining MEDIAN_PIVOT_SHORTCUT_EN.
module median_last_actor #(
  parameter int BUFF_SIZE     = 16,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  input  logic [7:0]               in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [7:0]               in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,
  output logic [7:0]               out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full,
  output logic                     out_busy
);
  localparam int CW = BUFF_SIZE_BIT + 1;
  localparam int IW = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
  localparam logic [BUFF_SIZE_BIT-1:0] MAX_SIZE = BUFF_SIZE_BIT'(BUFF_SIZE);

  typedef enum logic [2:0] {IDLE, SAMPLE, LOAD, SCAN, EMIT} state_t;
  state_t state, state_nx;

  logic [7:0]    pix_buf [BUFF_SIZE];
  logic [7:0]    pivot, result, cand, jval;
  logic [CW-1:0] size, pos, cnt, i, j, lt, eq;
  logic [CW-1:0] size_in, pos_eff, lt_nx, eq_nx;
  logic          ctl_ready, pop, last_j, sel, pivot_pass, done;

  assign size_in   = CW'((in_buff_size > MAX_SIZE) ? MAX_SIZE : in_buff_size);
  assign ctl_ready = ~(in_pivot_empty | in_buff_size_empty | in_median_pos_empty |
                       in_second_median_value_empty);
  assign pop       = (state == LOAD) & ~in_px_empty & ~reset;

  // Candidate is the pivot during the shortcut pass, else buf[i]; j streams one compare per cycle.
  assign jval    = pix_buf[j[IW-1:0]];
  assign cand    = pivot_pass ? pivot : pix_buf[i[IW-1:0]];
  // Out-of-range rank clamps to size-1, which the selection rule resolves to the maximum.
  assign pos_eff = (pos >= size) ? size - CW'(1) : pos;
  assign lt_nx   = lt + CW'(jval < cand);
  assign eq_nx   = eq + CW'(jval == cand);
  assign last_j  = (j == size - CW'(1));
  assign sel     = last_j && (lt_nx <= pos_eff) && (pos_eff < lt_nx + eq_nx);
  assign done    = last_j && (sel || (!pivot_pass && i == size - CW'(1)));

  assign out_median = result;

`ifdef MEDIAN_PIVOT_SHORTCUT_EN
  always_ff @(posedge clock) begin
    if (reset)                       pivot_pass <= 1'b0;
    else if (state == SAMPLE)        pivot_pass <= 1'b1;
    else if (state == SCAN && last_j) pivot_pass <= 1'b0;
  end
`else
  assign pivot_pass = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx                  = state;
    in_px_rd                  = 1'b0;
    in_pivot_rd               = 1'b0;
    in_buff_size_rd           = 1'b0;
    in_median_pos_rd          = 1'b0;
    in_second_median_value_rd = 1'b0;
    out_median_wr             = 1'b0;
    out_busy                  = (state != IDLE);
    case (state)
      IDLE:   if (ctl_ready) state_nx = SAMPLE;
      SAMPLE: begin
        in_pivot_rd               = 1'b1;
        in_buff_size_rd           = 1'b1;
        in_median_pos_rd          = 1'b1;
        in_second_median_value_rd = 1'b1;
        state_nx = (size_in == '0) ? EMIT : LOAD;
      end
      LOAD: begin
        in_px_rd = pop;
        if (pop && (cnt + CW'(1) == size)) state_nx = SCAN;
      end
      SCAN: if (done) state_nx = EMIT;
      EMIT: begin
        out_median_wr = ~out_median_full;
        if (!out_median_full) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      in_pivot_rd               = 1'b0;
      in_buff_size_rd           = 1'b0;
      in_median_pos_rd          = 1'b0;
      in_second_median_value_rd = 1'b0;
      out_median_wr             = 1'b0;
      out_busy                  = 1'b0;
    end
  end

  // Buffer is intentionally not reset; stale contents are never read before reload.
  always_ff @(posedge clock) begin
    if (pop) pix_buf[cnt[IW-1:0]] <= in_px;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0; i <= '0; j <= '0; lt <= '0; eq <= '0;
      size <= '0; pos <= '0; pivot <= '0; result <= '0;
    end else begin
      case (state)
        SAMPLE: begin
          pivot <= in_pivot;
          size  <= size_in;
          pos   <= CW'(in_median_pos);
          cnt <= '0; i <= '0; j <= '0; lt <= '0; eq <= '0;
          if (size_in == '0) result <= in_second_median_value;
        end
        LOAD: if (pop) cnt <= cnt + CW'(1);
        SCAN: begin
          if (last_j) begin
            j <= '0; lt <= '0; eq <= '0;
            if (done)             result <= cand;
            else if (!pivot_pass) i <= i + CW'(1);
          end else begin
            j  <= j + CW'(1);
            lt <= lt_nx;
            eq <= eq_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
